// File: rtl/sram_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the parametrised SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_ADDR_W   = 3;
    localparam int unsigned DEF_READ_LAT = 2;

    function automatic bit params_ok(input int unsigned data_w, input int unsigned read_lat);
        return (data_w != 0) && ((data_w % 8) == 0) && ((read_lat == 1) || (read_lat == 2));
    endfunction

    function automatic int unsigned calc_be_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned calc_depth(input int unsigned addr_w);
        return 32'(1) << addr_w;
    endfunction

endpackage

// File: rtl/sram_ctrl_param_array.sv
// DEPTH x DATA_W storage: byte-enable write port, registered read port.
module sram_array
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int unsigned BE_W  = calc_be_w(DATA_W);
    localparam int unsigned DEPTH = calc_depth(ADDR_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage is intentionally not reset; the controller clears it when configured to.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_ctrl_param.sv
// Parametrised single-port SRAM controller: valid/ready requests, byte-enable
// writes, optional hardware clear and a one- or two-stage read pipeline.
module sram_ctrl_param
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned READ_LAT   = DEF_READ_LAT,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  busy,
    output logic                  init_done
);

    localparam int unsigned BE_W      = calc_be_w(DATA_W);
    localparam int unsigned DEPTH     = calc_depth(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam state_t RST_STATE      = (INIT_CLEAR != 0) ? S_INIT : S_RUN;

    generate
        if (!params_ok(DATA_W, READ_LAT)) begin : g_bad_params
            $error("sram_ctrl_param: DATA_W must be a multiple of 8 and READ_LAT must be 1 or 2");
        end
    endgenerate

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic                r_init_done;
    logic                r_rd_v1;
    logic                w_clr;
    logic                w_accept;
    logic                w_wr;
    logic                w_rd;
    logic                w_clearing;
    logic                w_arr_we;
    logic [ADDR_W-1:0]   w_arr_waddr;
    logic [DATA_W-1:0]   w_arr_wdata;
    logic [BE_W-1:0]     w_arr_be;
    logic [DATA_W-1:0]   w_arr_rdata;

    assign w_clr      = clr && (INIT_CLEAR != 0);
    assign w_clearing = (r_state == S_INIT);
    // rst gating keeps req_ready low while reset is held even when no clear is configured.
    assign req_ready  = (r_state == S_RUN) && !w_clr && !rst;
    assign w_accept   = req_valid && req_ready;
    assign w_wr       = w_accept && req_we;
    assign w_rd       = w_accept && !req_we;
    assign busy       = w_clearing;
    assign init_done  = r_init_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RST_STATE;
            r_clr_addr  <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= 1'b0;
            case (r_state)
                S_INIT: begin
                    if (w_clr) begin
                        r_clr_addr <= '0;
                    end else if (r_clr_addr == LAST_ADDR) begin
                        r_state     <= S_RUN;
                        r_clr_addr  <= '0;
                        r_init_done <= 1'b1;
                    end else begin
                        r_clr_addr <= r_clr_addr + ADDR_W'(1);
                    end
                end
                S_RUN: begin
                    if (w_clr) begin
                        r_state    <= S_INIT;
                        r_clr_addr <= '0;
                    end
                end
            endcase
        end
    end

    // The clear sequence owns the write port while busy.
    assign w_arr_we    = w_clearing || w_wr;
    assign w_arr_waddr = w_clearing ? r_clr_addr : req_addr;
    assign w_arr_wdata = w_clearing ? '0 : req_wdata;
    assign w_arr_be    = w_clearing ? '1 : req_be;

    sram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_arr_we),
        .i_waddr (w_arr_waddr),
        .i_wdata (w_arr_wdata),
        .i_be    (w_arr_be),
        .i_re    (w_rd),
        .i_raddr (req_addr),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_v1 <= 1'b0;
        end else begin
            r_rd_v1 <= w_rd;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              r_rsp_valid;
            logic [DATA_W-1:0] r_rsp_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_data  <= '0;
                end else begin
                    r_rsp_valid <= r_rd_v1;
                    if (r_rd_v1) begin
                        r_rsp_data <= w_arr_rdata;
                    end
                end
            end

            assign rsp_valid = r_rsp_valid;
            assign rsp_data  = r_rsp_data;
        end else begin : g_lat1
            assign rsp_valid = r_rd_v1;
            assign rsp_data  = w_arr_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Scoreboard bench for sram_ctrl_param: READ_LAT=2/INIT_CLEAR=1 and READ_LAT=1/INIT_CLEAR=0 instances.
module tb_sram_ctrl_param;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid, busy, init_done;
    logic [15:0] rsp_data;

    logic        clr_1;
    logic        req_valid_1, req_ready_1, req_we_1;
    logic [2:0]  req_addr_1;
    logic [15:0] req_wdata_1;
    logic [1:0]  req_be_1;
    logic        rsp_valid_1, busy_1, init_done_1;
    logic [15:0] rsp_data_1;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    sram_ctrl_param #(.DATA_W(16), .ADDR_W(3), .READ_LAT(2), .INIT_CLEAR(1)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .init_done(init_done)
    );

    sram_ctrl_param #(.DATA_W(16), .ADDR_W(3), .READ_LAT(1), .INIT_CLEAR(0)) dut1 (
        .clk(clk), .rst(rst), .clr(clr_1),
        .req_valid(req_valid_1), .req_ready(req_ready_1), .req_we(req_we_1),
        .req_addr(req_addr_1), .req_wdata(req_wdata_1), .req_be(req_be_1),
        .rsp_valid(rsp_valid_1), .rsp_data(rsp_data_1),
        .busy(busy_1), .init_done(init_done_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitors: pop the expected entry and check data and arrival cycle.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (q0.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp0_unexpected: got data 0x%0h with no read outstanding", rsp_data);
            end else begin
                e0 = q0.pop_front();
                check("rsp0_data", 32'(rsp_data), 32'(e0.data));
                check("rsp0_cycle", 32'(cyc), 32'(e0.due));
            end
        end
        if (rsp_valid_1) begin
            if (q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp1_unexpected: got data 0x%0h with no read outstanding", rsp_data_1);
            end else begin
                e1 = q1.pop_front();
                check("rsp1_data", 32'(rsp_data_1), 32'(e1.data));
                check("rsp1_cycle", 32'(cyc), 32'(e1.due));
            end
        end
    end

    // Issue one request on the READ_LAT=2 instance; call #1 after a posedge.
    task automatic send(input logic we, input logic [2:0] a, input logic [15:0] d,
                        input logic [1:0] be, input logic [15:0] exp_d);
        int waited;
        waited    = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: addr %0d never accepted", a);
        end else if (!we) begin
            q0.push_back(exp_t'{exp_d, cyc + 2});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic check_clear(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_ready"}, 32'(req_ready), 32'd0);
            check({tag, "_done_early"}, 32'(init_done), 32'd0);
        end
        @(negedge clk);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; clr_1 = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        req_valid_1 = 1'b0; req_we_1 = 1'b0; req_addr_1 = '0; req_wdata_1 = '0; req_be_1 = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst1_ready", 32'(req_ready_1), 32'd0);
        check("rst1_busy", 32'(busy_1), 32'd0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        fork
            begin : t1_clear_then_read
                req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd5; req_be = 2'b00;
                check_clear("t1");
                check("t1_ready_with_done", 32'(req_ready), 32'd1);
                q0.push_back(exp_t'{16'h0000, cyc + 2});
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                @(negedge clk);
                check("t1_done_single", 32'(init_done), 32'd0);
            end
            begin : t6_lat1_no_clear
                req_valid_1 = 1'b1; req_we_1 = 1'b1; req_addr_1 = 3'd2;
                req_wdata_1 = 16'h00C3; req_be_1 = 2'b11;
                @(negedge clk);
                check("t6_ready_first", 32'(req_ready_1), 32'd1);
                @(posedge clk);
                #1;
                req_we_1 = 1'b0;
                @(negedge clk);
                check("t6_ready_read", 32'(req_ready_1), 32'd1);
                q1.push_back(exp_t'{16'h00C3, cyc + 1});
                @(posedge clk);
                #1;
                req_valid_1 = 1'b0;
            end
        join

        // Back-to-back writes then back-to-back reads.
        send(1'b1, 3'd0, 16'h1234, 2'b11, 16'h0);
        send(1'b1, 3'd7, 16'h5678, 2'b11, 16'h0);
        send(1'b0, 3'd0, 16'h0000, 2'b00, 16'h1234);
        send(1'b0, 3'd7, 16'h0000, 2'b00, 16'h5678);

        // Byte enables, including the all-zero no-op.
        send(1'b1, 3'd3, 16'hAAAA, 2'b11, 16'h0);
        send(1'b1, 3'd3, 16'h55FF, 2'b01, 16'h0);
        send(1'b0, 3'd3, 16'h0000, 2'b11, 16'hAAFF);
        send(1'b1, 3'd3, 16'h9999, 2'b00, 16'h0);
        send(1'b0, 3'd3, 16'h0000, 2'b00, 16'hAAFF);
        send(1'b1, 3'd3, 16'h1100, 2'b10, 16'h0);
        send(1'b0, 3'd3, 16'h0000, 2'b00, 16'h11FF);

        // Read in flight while clr arrives alongside a competing write.
        send(1'b0, 3'd0, 16'h0000, 2'b00, 16'h1234);
        clr = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd0; req_wdata = 16'hFFFF; req_be = 2'b11;
        @(negedge clk);
        check("t4_ready_during_clr", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        req_valid = 1'b0;
        check_clear("t4");
        @(posedge clk);
        #1;
        send(1'b0, 3'd0, 16'h0000, 2'b00, 16'h0000);
        send(1'b0, 3'd7, 16'h0000, 2'b00, 16'h0000);

        // Reset in the middle of a clear sequence.
        send(1'b1, 3'd3, 16'h11FF, 2'b11, 16'h0);
        send(1'b1, 3'd6, 16'hBEEF, 2'b11, 16'h0);
        send(1'b0, 3'd3, 16'h0000, 2'b00, 16'h11FF);
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd1);
        check("t5_rst_ready", 32'(req_ready), 32'd0);
        check("t5_rst_done", 32'(init_done), 32'd0);
        check("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_rst_rsp_data", 32'(rsp_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_clear("t5");
        @(posedge clk);
        #1;
        send(1'b0, 3'd6, 16'h0000, 2'b00, 16'h0000);
        send(1'b0, 3'd3, 16'h0000, 2'b00, 16'h0000);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
